data_memory_ctrl: RTL and testbench

- Parametrised successor to the single-cycle word data memory used by the MIPS datapath.
- Adds byte, halfword and word access with sign or zero extension, a configurable depth and top address, and a registered one-cycle read response.
- Detects misaligned, out-of-range and illegal requests.
- Zero-fills the whole array after reset, sweeping one word per clock.
- Sits between the MEM stage and the datapath's load/store control.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/load_align.sv | 34 +++
 rtl/data_memory_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the data memory controller: access
//               sizes, fault codes, FSM states and the alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Fault codes reported alongside a rejected request
  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

  // Controller states: INIT zero-fills the array, IDLE serves requests
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // Halfwords need an even address, words a 4-byte aligned address
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/halfword lane of a little-endian
//               32-bit word and sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_load_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select followed by extension; word and reserved sizes pass through
  always_comb begin
    w_byte = i_word[8*i_addr_lo +: 8];
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    o_data = i_word;
    case (i_size)
      SZ_BYTE: o_data = {{24{w_byte[7] & ~i_load_unsigned}}, w_byte};
      SZ_HALF: o_data = {{16{w_half[15] & ~i_load_unsigned}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ctrl
// Description : Word-organised data memory with byte/half/word access,
//               request checking, registered one-cycle response and a
//               post-reset zero-fill sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int                DEPTH    = 256,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] TOP_ADDR = 32'h7FFFFFFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              resp_valid,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int                IDX_W       = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] c_base_addr = TOP_ADDR - ADDR_W'(4 * (DEPTH - 1));
  localparam logic [ADDR_W-1:0] c_last_byte = TOP_ADDR + ADDR_W'(3);
  localparam logic [IDX_W-1:0]  c_last_ptr  = IDX_W'(DEPTH - 1);

  // Storage and control state
  logic [31:0]      r_mem [DEPTH];
  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_init_ptr;

  logic [31:0] r_read_data;
  logic        r_resp_valid;
  logic        r_fault;
  logic [1:0]  r_fault_code;

  // Request decode
  logic              w_accept;
  logic              w_illegal;
  logic              w_range;
  logic              w_misalign;
  logic [1:0]        w_code;
  logic              w_store_ok;
  logic [ADDR_W-1:0] w_offset;
  logic [IDX_W-1:0]  w_index;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_word;
  logic [31:0]       w_aligned;
  logic              w_unused;

  assign req_ready = (r_state == ST_IDLE);

  // Reset takes priority over any request presented in the same cycle
  assign w_accept = req_valid & req_ready & (mem_read | mem_write) & ~reset;

  assign w_illegal  = (mem_read & mem_write) | (size == SZ_RSVD);
  assign w_range    = (address < c_base_addr) | (address > c_last_byte);
  assign w_misalign = is_misaligned(size, address[1:0]);

  // Fault priority: illegal, then out of range, then misaligned
  always_comb begin
    w_code = FLT_NONE;
    if (w_illegal) begin
      w_code = FLT_ILLEGAL;
    end else if (w_range) begin
      w_code = FLT_RANGE;
    end else if (w_misalign) begin
      w_code = FLT_MISALIGN;
    end
  end

  assign w_store_ok = w_accept & mem_write & (w_code == FLT_NONE);

  // Word index relative to the bottom of the window; only meaningful in range
  assign w_offset = address - c_base_addr;
  assign w_index  = w_offset[IDX_W+1:2];
  assign w_unused = ^{w_offset[ADDR_W-1:IDX_W+2], w_offset[1:0]};

  // Byte enables and lane-replicated store data for little-endian lanes
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = write_data;
    case (size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << address[1:0];
        w_wdata = {4{write_data[7:0]}};
      end
      SZ_HALF: begin
        w_be    = address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{write_data[15:0]}};
      end
      SZ_WORD: begin
        w_be    = 4'b1111;
        w_wdata = write_data;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = write_data;
      end
    endcase
  end

  // Asynchronous array read; a store in the previous cycle is already visible
  assign w_word = r_mem[w_index];

  load_align u_load_align (
    .i_word          (w_word),
    .i_addr_lo       (address[1:0]),
    .i_size          (size),
    .i_load_unsigned (load_unsigned),
    .o_data          (w_aligned)
  );

  // FSM state register and zero-fill pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_INIT) begin
        r_init_ptr <= r_init_ptr + 1'b1;
      end
    end
  end

  // Next-state logic: leave INIT once the last word has been cleared
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: if (r_init_ptr == c_last_ptr) w_state_next = ST_IDLE;
      ST_IDLE: w_state_next = ST_IDLE;
      default: w_state_next = ST_INIT;
    endcase
  end

  // Array writes: zero-fill sweep during INIT, lane-masked stores in IDLE
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_init_ptr] <= '0;
    end else if (w_store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_index][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered response; read_data only changes on a load or a fault
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_data  <= '0;
      r_resp_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= FLT_NONE;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_fault      <= (w_code != FLT_NONE);
      r_fault_code <= w_code;
      if (w_code != FLT_NONE) begin
        r_read_data <= '0;
      end else if (mem_read) begin
        r_read_data <= w_aligned;
      end
    end else begin
      r_resp_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= FLT_NONE;
    end
  end

  assign read_data  = r_read_data;
  assign resp_valid = r_resp_valid;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;

endmodule : data_memory_ctrl
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_ctrl
// Description : Directed self-checking bench for data_memory_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

  localparam int          DEPTH = 256;
  localparam logic [31:0] TOP   = 32'h7FFFFFFC;
  localparam logic [31:0] BASE  = 32'h7FFFFC00;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        resp_valid;
  logic        fault;
  logic [1:0]  fault_code;

  int errors = 0;
  int checks = 0;
  int n;
  int bad;

  data_memory_ctrl #(
    .DEPTH    (DEPTH),
    .ADDR_W   (32),
    .TOP_ADDR (TOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .size          (size),
    .load_unsigned (load_unsigned),
    .address       (address),
    .write_data    (write_data),
    .read_data     (read_data),
    .resp_valid    (resp_valid),
    .fault         (fault),
    .fault_code    (fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    req_valid     = 1'b1;
    mem_read      = rd;
    mem_write     = wr;
    size          = sz;
    load_unsigned = uns;
    address       = a;
    write_data    = wd;
    step();
  endtask

  task automatic idle();
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] data, input logic flt,
                          input logic [1:0] code);
    chk({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, "_fault"}, {31'b0, fault}, {31'b0, flt});
    chk({tag, "_code"}, {30'b0, fault_code}, {30'b0, code});
    chk({tag, "_data"}, read_data, data);
  endtask

  // Counts cycles with req_ready low (bounded) and any stray responses
  task automatic count_init();
    n   = 0;
    bad = 0;
    while (req_ready !== 1'b1 && n < DEPTH + 8) begin
      if (resp_valid !== 1'b0) bad++;
      step();
      n++;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    size          = 2'b10;
    load_unsigned = 1'b0;
    address       = '0;
    write_data    = '0;
    step();
    step();
    chk("rst_data", read_data, 32'h0);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_code", {30'b0, fault_code}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);

    // Load held during INIT is ignored until the sweep completes
    req_valid = 1'b1; mem_read = 1'b1; size = 2'b10; address = TOP;
    reset = 1'b0;
    count_init();
    chk("init_len", n, DEPTH);
    chk("init_noresp", bad, 0);
    step();
    chk_resp("init_top", 32'h0, 1'b0, 2'b00);

    // Word store then loads of every lane shape
    do_req(1'b0, 1'b1, 2'b10, 1'b0, TOP, 32'hDEADBEEF);
    chk_resp("st_word", 32'h0, 1'b0, 2'b00);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, TOP, 32'h0);
    chk_resp("ld_word", 32'hDEADBEEF, 1'b0, 2'b00);
    do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h7FFFFFFF, 32'h0);
    chk_resp("ld_byte_s", 32'hFFFFFFDE, 1'b0, 2'b00);
    do_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h7FFFFFFF, 32'h0);
    chk_resp("ld_byte_u", 32'h000000DE, 1'b0, 2'b00);
    do_req(1'b1, 1'b0, 2'b01, 1'b0, TOP, 32'h0);
    chk_resp("ld_half_s", 32'hFFFFBEEF, 1'b0, 2'b00);

    // Byte store touches one lane; read_data holds across the store response
    do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h7FFFFFFD, 32'hAAAAAA12);
    chk_resp("st_byte", 32'hFFFFBEEF, 1'b0, 2'b00);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, TOP, 32'h0);
    chk_resp("ld_after_byte", 32'hDEAD12EF, 1'b0, 2'b00);

    // Faults and their effect on memory
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h7FFFFFFE, 32'h0);
    chk_resp("flt_mis_ld", 32'h0, 1'b1, 2'b01);
    do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h7FFFFFFD, 32'h0);
    chk_resp("flt_mis_half", 32'h0, 1'b1, 2'b01);
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h7FFFFFFE, 32'h01234567);
    chk_resp("flt_mis_st", 32'h0, 1'b1, 2'b01);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, BASE - 32'd4, 32'h0);
    chk_resp("flt_rng_lo", 32'h0, 1'b1, 2'b10);
    do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h80000000, 32'h0);
    chk_resp("flt_rng_hi", 32'h0, 1'b1, 2'b10);
    do_req(1'b1, 1'b1, 2'b10, 1'b0, TOP, 32'h0);
    chk_resp("flt_ill_rw", 32'h0, 1'b1, 2'b11);
    do_req(1'b0, 1'b1, 2'b11, 1'b0, 32'h7FFFFFFE, 32'h0);
    chk_resp("flt_ill_sz", 32'h0, 1'b1, 2'b11);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, TOP, 32'h0);
    chk_resp("flt_mem_kept", 32'hDEAD12EF, 1'b0, 2'b00);

    // No request, and valid with neither read nor write: no response
    idle();
    step();
    chk("idle_valid", {31'b0, resp_valid}, 32'd0);
    chk("idle_fault", {31'b0, fault}, 32'd0);
    chk("idle_code", {30'b0, fault_code}, 32'd0);
    req_valid = 1'b1;
    step();
    chk("noop_valid", {31'b0, resp_valid}, 32'd0);
    chk("noop_data", read_data, 32'hDEAD12EF);

    // Back-to-back store/load at the bottom word (read-after-write)
    do_req(1'b0, 1'b1, 2'b10, 1'b0, BASE, 32'h11223344);
    chk_resp("raw_st", 32'hDEAD12EF, 1'b0, 2'b00);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, BASE, 32'h0);
    chk_resp("raw_ld", 32'h11223344, 1'b0, 2'b00);
    do_req(1'b0, 1'b1, 2'b01, 1'b0, BASE + 32'd2, 32'hFFFF8001);
    chk_resp("st_half", 32'h11223344, 1'b0, 2'b00);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, BASE, 32'h0);
    chk_resp("ld_after_half", 32'h80013344, 1'b0, 2'b00);
    do_req(1'b1, 1'b0, 2'b01, 1'b1, BASE + 32'd2, 32'h0);
    chk_resp("ld_half_u", 32'h00008001, 1'b0, 2'b00);
    do_req(1'b1, 1'b0, 2'b01, 1'b0, BASE + 32'd2, 32'h0);
    chk_resp("ld_half_hi_s", 32'hFFFF8001, 1'b0, 2'b00);
    do_req(1'b1, 1'b0, 2'b00, 1'b0, BASE + 32'd1, 32'h0);
    chk_resp("ld_byte_pos", 32'h00000033, 1'b0, 2'b00);

    // Reset after stores, then again mid-INIT at cycle 100
    idle();
    reset = 1'b1;
    step();
    chk("rst2_data", read_data, 32'h0);
    chk("rst2_ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (req_ready !== 1'b0) bad++;
      step();
    end
    chk("mid_init_ready", bad, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = 1'b1; mem_read = 1'b1; size = 2'b10; address = TOP;
    count_init();
    chk("reinit_len", n, DEPTH);
    chk("reinit_noresp", bad, 0);
    step();
    chk_resp("reinit_top", 32'h0, 1'b0, 2'b00);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, BASE, 32'h0);
    chk_resp("reinit_base", 32'h0, 1'b0, 2'b00);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_data_memory_ctrl
`default_nettype wire
